// File: rtl/dac_readback_remap.sv
// dac_readback_remap: physical->logical DAC readback remap into a 32-entry
// logical-indexed register file with per-entry freshness, an all-fresh flag
// and a saturating count of writes that landed on still-fresh entries.

// One register-file entry: value plus freshness flag.
module dac_rb_entry #(
  parameter int DATA_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 rd_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 fresh
);

  // Write sets fresh; a host read clears it unless a write lands on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      fresh <= 1'b0;
    end else begin
      if (wr) data <= wdata;
      if (wr)          fresh <= 1'b1;
      else if (rd_clr) fresh <= 1'b0;
    end
  end

endmodule

module dac_readback_remap #(
  parameter int DATA_BITS = 12,
  parameter int OVF_BITS  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rb_valid_i,
  output logic                 rb_ready_o,
  input  logic [4:0]           rb_dac_addr_i,
  input  logic [DATA_BITS-1:0] rb_data_i,
  input  logic                 freeze_i,
  input  logic                 rd_en_i,
  input  logic [4:0]           rd_addr_i,
  output logic [DATA_BITS-1:0] rd_data_o,
  output logic                 rd_fresh_o,
  output logic                 all_fresh_o,
  output logic [OVF_BITS-1:0]  overwrite_cnt_o
);

  localparam int NUM_ENT = 32;
  localparam int STAGES  = 1;

  // Physical DAC channel -> logical register index. Covers all 32 codes.
  function automatic logic [4:0] phys2log(input logic [4:0] p);
    logic [4:0] l;
    l = 5'h00;
    case (p)
      5'd8:  l = 5'h00;
      5'd12: l = 5'h01;
      5'd14: l = 5'h02;
      5'd16: l = 5'h03;
      5'd20: l = 5'h04;
      5'd22: l = 5'h05;
      5'd9:  l = 5'h06;
      5'd13: l = 5'h07;
      5'd15: l = 5'h08;
      5'd17: l = 5'h09;
      5'd21: l = 5'h0A;
      5'd23: l = 5'h0B;
      5'd10: l = 5'h0C;
      5'd11: l = 5'h0D;
      5'd18: l = 5'h0E;
      5'd19: l = 5'h0F;
      default: begin
        // 0-7 -> 0x10-0x17, 24-31 map onto themselves (0x18-0x1F)
        if (p < 5'd8) l = {2'b10, p[2:0]};
        else          l = p;
      end
    endcase
    return l;
  endfunction

  logic [STAGES:0]                      vld_pipe;
  logic [4:0]                           s1_addr;
  logic [DATA_BITS-1:0]                 s1_data;
  logic [NUM_ENT-1:0]                   wr_vec;
  logic [NUM_ENT-1:0]                   clr_vec;
  logic [NUM_ENT-1:0]                   fresh_vec;
  logic [NUM_ENT-1:0]                   fresh_nxt;
  logic [NUM_ENT-1:0][DATA_BITS-1:0]    data_arr;

  // Only freeze (or reset) stalls the input; the pipe itself never fills up.
  assign rb_ready_o  = ~freeze_i & ~rst_i;
  assign vld_pipe[0] = rb_valid_i & rb_ready_o;

  // Stage 1: capture remapped address and data of an accepted word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe[STAGES:1] <= '0;
      s1_addr            <= '0;
      s1_data            <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (vld_pipe[0]) begin
        s1_addr <= phys2log(rb_dac_addr_i);
        s1_data <= rb_data_i;
      end
    end
  end

  // Per-entry write / read-clear decode and the register file itself.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENT; gi++) begin : g_ent
      assign wr_vec[gi]  = vld_pipe[STAGES] && (s1_addr == 5'(gi));
      assign clr_vec[gi] = rd_en_i && (rd_addr_i == 5'(gi));
      dac_rb_entry #(.DATA_BITS(DATA_BITS)) u_ent (
        .clk    (clk_i),
        .rst    (rst_i),
        .wr     (wr_vec[gi]),
        .wdata  (s1_data),
        .rd_clr (clr_vec[gi]),
        .data   (data_arr[gi]),
        .fresh  (fresh_vec[gi])
      );
    end
  endgenerate

  // Freshness as it will be after this edge (write beats read-clear).
  assign fresh_nxt = (fresh_vec & ~clr_vec) | wr_vec;

  // Host read returns pre-edge contents; all_fresh tracks the post-edge vector.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_o   <= '0;
      rd_fresh_o  <= 1'b0;
      all_fresh_o <= 1'b0;
    end else begin
      if (rd_en_i) begin
        rd_data_o  <= data_arr[rd_addr_i];
        rd_fresh_o <= fresh_vec[rd_addr_i];
      end
      all_fresh_o <= &fresh_nxt;
    end
  end

  // Count writes landing on an entry that was still fresh before the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overwrite_cnt_o <= '0;
    end else if (vld_pipe[STAGES] && fresh_vec[s1_addr] && !(&overwrite_cnt_o)) begin
      overwrite_cnt_o <= overwrite_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_dac_readback_remap.sv
// Directed bench for dac_readback_remap with hand-computed expectations.
module tb_dac_readback_remap;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        rb_valid_i = 1'b0;
  logic        rb_ready_o;
  logic [4:0]  rb_dac_addr_i = '0;
  logic [11:0] rb_data_i = '0;
  logic        freeze_i = 1'b0;
  logic        rd_en_i = 1'b0;
  logic [4:0]  rd_addr_i = '0;
  logic [11:0] rd_data_o;
  logic        rd_fresh_o;
  logic        all_fresh_o;
  logic [7:0]  overwrite_cnt_o;

  int n_chk  = 0;
  int n_pass = 0;

  // Logical -> physical channel, written out from the channel plan.
  logic [4:0] fwd [32] = '{
    5'd8,  5'd12, 5'd14, 5'd16, 5'd20, 5'd22, 5'd9,  5'd13,
    5'd15, 5'd17, 5'd21, 5'd23, 5'd10, 5'd11, 5'd18, 5'd19,
    5'd0,  5'd1,  5'd2,  5'd3,  5'd4,  5'd5,  5'd6,  5'd7,
    5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31};

  dac_readback_remap #(.DATA_BITS(12), .OVF_BITS(8)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .rb_valid_i      (rb_valid_i),
    .rb_ready_o      (rb_ready_o),
    .rb_dac_addr_i   (rb_dac_addr_i),
    .rb_data_i       (rb_data_i),
    .freeze_i        (freeze_i),
    .rd_en_i         (rd_en_i),
    .rd_addr_i       (rd_addr_i),
    .rd_data_o       (rd_data_o),
    .rd_fresh_o      (rd_fresh_o),
    .all_fresh_o     (all_fresh_o),
    .overwrite_cnt_o (overwrite_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [4:0] p, input logic [11:0] d);
    rb_valid_i = 1'b1; rb_dac_addr_i = p; rb_data_i = d;
    tick(1);
    rb_valid_i = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a);
    rd_en_i = 1'b1; rd_addr_i = a;
    tick(1);
    rd_en_i = 1'b0;
  endtask

  initial begin
    // 1. reset and idle
    tick(2);
    chk("ready_in_reset", 32'(rb_ready_o), 0);
    rst_i = 1'b0;
    tick(5);
    chk("ready_idle", 32'(rb_ready_o), 1);
    chk("rd_data_rst", 32'(rd_data_o), 0);
    chk("rd_fresh_rst", 32'(rd_fresh_o), 0);
    chk("all_fresh_rst", 32'(all_fresh_o), 0);
    chk("ovf_rst", 32'(overwrite_cnt_o), 0);
    for (int a = 0; a < 32; a++) begin
      rd(5'(a));
      chk($sformatf("rst_data[%0d]", a), 32'(rd_data_o), 0);
      chk($sformatf("rst_fresh[%0d]", a), 32'(rd_fresh_o), 0);
    end

    // 2. single write phys 8 -> logical 0
    push(5'd8, 12'hABC);
    tick(1);
    rd(5'h00);
    chk("t2_data", 32'(rd_data_o), 32'hABC);
    chk("t2_fresh", 32'(rd_fresh_o), 1);
    rd(5'h00);
    chk("t2_data2", 32'(rd_data_o), 32'hABC);
    chk("t2_fresh2", 32'(rd_fresh_o), 0);

    // 3. back-to-back sweep of every physical channel
    for (int p = 0; p < 32; p++) begin
      rb_valid_i = 1'b1; rb_dac_addr_i = 5'(p); rb_data_i = 12'(p * 3);
      tick(1);
    end
    rb_valid_i = 1'b0;
    chk("t3_af_pending", 32'(all_fresh_o), 0);
    tick(1);
    chk("t3_af_set", 32'(all_fresh_o), 1);
    chk("t3_ovf0", 32'(overwrite_cnt_o), 0);
    for (int p = 0; p < 32; p++) begin
      rb_valid_i = 1'b1; rb_dac_addr_i = 5'(p); rb_data_i = 12'(p * 3);
      tick(1);
    end
    rb_valid_i = 1'b0;
    tick(1);
    chk("t3_ovf32", 32'(overwrite_cnt_o), 32);
    for (int l = 0; l < 32; l++) begin
      rd(5'(l));
      chk($sformatf("t3_data[%0d]", l), 32'(rd_data_o), 32'(fwd[l]) * 3);
      chk($sformatf("t3_fresh[%0d]", l), 32'(rd_fresh_o), 1);
    end
    chk("t3_af_clr", 32'(all_fresh_o), 0);

    // 4. read and write of the same entry on one edge
    push(5'd12, 12'h222);
    tick(1);
    rb_valid_i = 1'b1; rb_dac_addr_i = 5'd12; rb_data_i = 12'h111;
    tick(1);
    rb_valid_i = 1'b0;
    rd_en_i = 1'b1; rd_addr_i = 5'h01;
    tick(1);
    rd_en_i = 1'b0;
    chk("t4_old_data", 32'(rd_data_o), 32'h222);
    chk("t4_old_fresh", 32'(rd_fresh_o), 1);
    chk("t4_ovf", 32'(overwrite_cnt_o), 33);
    rd(5'h01);
    chk("t4_new_data", 32'(rd_data_o), 32'h111);
    chk("t4_new_fresh", 32'(rd_fresh_o), 1);

    // 5. freeze with a word in flight and another held on the input
    push(5'd13, 12'h5A5);
    freeze_i = 1'b1;
    rb_valid_i = 1'b1; rb_dac_addr_i = 5'd14; rb_data_i = 12'h777;
    #1;
    chk("t5_ready_frz", 32'(rb_ready_o), 0);
    tick(3);
    rd(5'h02);
    chk("t5_frz_data", 32'(rd_data_o), 32'h02A);
    chk("t5_frz_fresh", 32'(rd_fresh_o), 0);
    rd(5'h07);
    chk("t5_inflight", 32'(rd_data_o), 32'h5A5);
    chk("t5_inflight_f", 32'(rd_fresh_o), 1);
    freeze_i = 1'b0;
    #1;
    chk("t5_ready_rel", 32'(rb_ready_o), 1);
    tick(1);
    rb_valid_i = 1'b0;
    tick(1);
    rd(5'h02);
    chk("t5_held_data", 32'(rd_data_o), 32'h777);
    chk("t5_held_fresh", 32'(rd_fresh_o), 1);
    chk("t5_ovf", 32'(overwrite_cnt_o), 33);

    // 6. reset with phys 31 in stage 1, then saturate the counter
    push(5'd31, 12'hFFF);
    rst_i = 1'b1;
    rb_valid_i = 1'b1; rb_dac_addr_i = 5'd0; rb_data_i = 12'h123;
    #1;
    chk("t6_ready_rst", 32'(rb_ready_o), 0);
    chk("t6_ovf_rst", 32'(overwrite_cnt_o), 0);
    tick(2);
    rb_valid_i = 1'b0;
    rst_i = 1'b0;
    tick(2);
    rd(5'h1F);
    chk("t6_1f_data", 32'(rd_data_o), 0);
    chk("t6_1f_fresh", 32'(rd_fresh_o), 0);
    rd(5'h10);
    chk("t6_10_data", 32'(rd_data_o), 0);
    chk("t6_af", 32'(all_fresh_o), 0);
    chk("t6_ovf0", 32'(overwrite_cnt_o), 0);
    rb_valid_i = 1'b1; rb_dac_addr_i = 5'd5; rb_data_i = 12'h0F0;
    tick(255);
    rb_valid_i = 1'b0;
    tick(1);
    chk("t6_ovf254", 32'(overwrite_cnt_o), 32'hFE);
    rb_valid_i = 1'b1;
    tick(46);
    rb_valid_i = 1'b0;
    tick(1);
    chk("t6_ovf_sat", 32'(overwrite_cnt_o), 32'hFF);
    rd(5'h15);
    chk("t6_15_data", 32'(rd_data_o), 32'h0F0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Hard stop in case something stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
